ram_arbiter: RTL and testbench

//  Round-robin controller that shares one 32x32 single-port synchronous RAM (ports clk/cen/wen/addr/din/dout)

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 40 ++++
 rtl/ram_arbiter.sv | 157 +++++++++++++++
 tb/tb_ram_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-master RAM arbiter: default widths,
// read-owner encoding and the init/run controller states.
// Optional build macro used by the arbiter: RAM_ARB_INIT_EN.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  // Owner tag carried alongside an in-flight read
  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  // Controller states (only exercised when RAM_ARB_INIT_EN is defined)
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// 2-way round-robin arbiter: grant is combinational from i_req, gated by i_advance.
// Latency: zero (grant in the same cycle as the request); pointer moves on the next edge.
// Backpressure: a losing requester simply sees no grant and keeps requesting.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);

  // 1 = m1 was granted last, so m0 wins the next tie; reset makes m0 preferred
  logic       r_last;
  logic [1:0] w_gnt;

  // Pick a winner; on a tie the requester not granted last wins
  always_comb begin
    w_gnt = 2'b00;
    if (i_advance) begin
      case (i_req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  // Remember the last winner; hold the pointer on cycles with no grant
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 1'b1;
    end else if (|w_gnt) begin
      r_last <= w_gnt[1];
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between masters m0/m1 with round-robin grants.
// Latency: gnt combinational; access on RAM pins 1 cycle later; read data/rvalid 2 cycles after gnt.
// Backpressure: requester holds req until gnt; no grants until init_done (RAM_ARB_INIT_EN adds a RAM fill phase).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef RAM_ARB_INIT_EN
  ,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_cen,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              init_done
);

  logic              r_ram_cen;
  logic              r_ram_wen;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_din;
  logic              r_init_done;

  // Read tag pipe: stage 1 follows the access on the RAM pins, stage 2 is the response cycle
  logic              r_tag1_vld;
  logic              r_tag1_own;
  logic              r_m0_rvalid;
  logic              r_m1_rvalid;

`ifdef RAM_ARB_INIT_EN
  state_t            r_state;
  logic [ADDR_W-1:0] r_init_addr;
`endif

  logic [1:0]        w_gnt;
  logic              w_any;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_nxt_cen;
  logic              w_nxt_wen;
  logic [ADDR_W-1:0] w_nxt_addr;
  logic [DATA_W-1:0] w_nxt_din;

  rr_arb2 u_rr_arb2 (
    .i_clk     (clk),
    .i_rst_n   (reset_n),
    .i_req     ({m1_req, m0_req}),
    .i_advance (r_init_done),
    .o_gnt     (w_gnt)
  );

  assign w_any  = |w_gnt;
  assign m0_gnt = w_gnt[0];
  assign m1_gnt = w_gnt[1];

  // Select the winner's command and form the next RAM pin values; address/data hold when unused
  always_comb begin
    w_we       = w_gnt[1] ? m1_we    : m0_we;
    w_addr     = w_gnt[1] ? m1_addr  : m0_addr;
    w_wdata    = w_gnt[1] ? m1_wdata : m0_wdata;
    w_nxt_cen  = w_any;
    w_nxt_wen  = w_any & w_we;
    w_nxt_addr = w_any ? w_addr : r_ram_addr;
    w_nxt_din  = (w_any && w_we) ? w_wdata : r_ram_din;
  end

  // RAM pin registers plus the init/run controller (fill phase only when RAM_ARB_INIT_EN)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ram_cen   <= 1'b0;
      r_ram_wen   <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
      r_init_done <= 1'b0;
`ifdef RAM_ARB_INIT_EN
      r_state     <= ST_INIT;
      r_init_addr <= '0;
`endif
    end else begin
`ifdef RAM_ARB_INIT_EN
      case (r_state)
        ST_INIT: begin
          r_ram_cen   <= 1'b1;
          r_ram_wen   <= 1'b1;
          r_ram_addr  <= r_init_addr;
          r_ram_din   <= INIT_VALUE;
          r_init_addr <= r_init_addr + ADDR_W'(1);
          if (r_init_addr == {ADDR_W{1'b1}}) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          // init_done rises one cycle after the last fill write reached the pins
          r_init_done <= 1'b1;
          r_ram_cen   <= w_nxt_cen;
          r_ram_wen   <= w_nxt_wen;
          r_ram_addr  <= w_nxt_addr;
          r_ram_din   <= w_nxt_din;
        end
      endcase
`else
      r_init_done <= 1'b1;
      r_ram_cen   <= w_nxt_cen;
      r_ram_wen   <= w_nxt_wen;
      r_ram_addr  <= w_nxt_addr;
      r_ram_din   <= w_nxt_din;
`endif
    end
  end

  // Track reads through the RAM so data returns to the master that issued them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag1_vld  <= 1'b0;
      r_tag1_own  <= OWN_M0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
    end else begin
      r_tag1_vld  <= w_any & ~w_we;
      r_tag1_own  <= w_gnt[1] ? OWN_M1 : OWN_M0;
      r_m0_rvalid <= r_tag1_vld & (r_tag1_own == OWN_M0);
      r_m1_rvalid <= r_tag1_vld & (r_tag1_own == OWN_M1);
    end
  end

  assign ram_cen   = r_ram_cen;
  assign ram_wen   = r_ram_wen;
  assign ram_addr  = r_ram_addr;
  assign ram_din   = r_ram_din;
  assign init_done = r_init_done;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rvalid ? ram_dout : '0;
  assign m1_rdata  = r_m1_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, transaction-level reference model, directed + random traffic.
// Drives inputs 1ns after posedge and samples outputs on negedge.
// Also builds with RAM_ARB_INIT_EN to cover the fill phase.
module tb_ram_arbiter;

  logic        clk;
  logic        reset_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [4:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_cen, ram_wen;
  logic [4:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic        init_done;

  int n_tests = 0;
  int n_fail  = 0;

  ram_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port synchronous RAM
  logic [31:0] ram_mem [0:31];
  always @(posedge clk) begin
    if (ram_cen) begin
      if (ram_wen) ram_mem[ram_addr] <= ram_din;
      else         ram_dout <= ram_mem[ram_addr];
    end
  end

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed { logic we; logic [4:0] addr; logic [31:0] data; } op_t;
  typedef struct { int due; bit own; logic [31:0] data; } rd_t;

  op_t         q0[$], q1[$];
  rd_t         rdq[$];
  logic [31:0] mdl_mem [0:31];
  int          mdl_last, cyc;
  bit          prev_any, prev_we;
  logic [4:0]  prev_addr;
  logic [31:0] prev_din;
  logic [1:0]  e_gnt;
  logic        e_cen, e_wen, e_rv0, e_rv1;
  logic [4:0]  e_addr;
  logic [31:0] e_din, e_rd0, e_rd1;

  task automatic model_reset();
    mdl_last = 1;
    rdq.delete();
    prev_any = 0;
    prev_we  = 0;
    e_gnt    = '0;
    cyc      = 0;
`ifdef RAM_ARB_INIT_EN
    foreach (mdl_mem[i]) mdl_mem[i] = '0;
`endif
  endtask

  // Expected outputs for the current cycle, then apply this cycle's grant
  task automatic model_step();
    rd_t r; int win; logic we; logic [4:0] a; logic [31:0] d;
    e_cen = prev_any; e_wen = prev_any & prev_we; e_addr = prev_addr; e_din = prev_din;
    e_rv0 = 0; e_rv1 = 0; e_rd0 = '0; e_rd1 = '0;
    if (rdq.size() != 0 && rdq[0].due == cyc) begin
      r = rdq.pop_front();
      if (r.own) begin e_rv1 = 1; e_rd1 = r.data; end
      else       begin e_rv0 = 1; e_rd0 = r.data; end
    end
    win = -1;
    if (m0_req && m1_req) win = (mdl_last == 0) ? 1 : 0;
    else if (m0_req)      win = 0;
    else if (m1_req)      win = 1;
    e_gnt = '0; prev_any = 0; prev_we = 0;
    if (win >= 0) begin
      we = (win == 1) ? m1_we : m0_we;
      a  = (win == 1) ? m1_addr : m0_addr;
      d  = (win == 1) ? m1_wdata : m0_wdata;
      e_gnt[win] = 1'b1; mdl_last = win;
      prev_any = 1; prev_we = we; prev_addr = a;
      if (we) begin prev_din = d; mdl_mem[a] = d; end
      else rdq.push_back('{cyc + 2, (win == 1), mdl_mem[a]});
    end
    cyc++;
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.we   = 1'($urandom_range(0, 1));
    o.addr = 5'($urandom_range(0, 7));
    o.data = $urandom;
    return o;
  endfunction

  // Retire granted ops, optionally drop/generate random ones, drive queue heads
  task automatic drive(input bit rnd);
    if (e_gnt[0]) void'(q0.pop_front());
    else if (rnd && q0.size() != 0 && $urandom_range(0, 7) == 0) void'(q0.pop_front());
    if (e_gnt[1]) void'(q1.pop_front());
    else if (rnd && q1.size() != 0 && $urandom_range(0, 7) == 0) void'(q1.pop_front());
    if (rnd && q0.size() == 0 && $urandom_range(0, 9) < 6) q0.push_back(rand_op());
    if (rnd && q1.size() == 0 && $urandom_range(0, 9) < 6) q1.push_back(rand_op());
    m0_req = (q0.size() != 0);
    m1_req = (q1.size() != 0);
    if (m0_req) begin m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].data; end
    if (m1_req) begin m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].data; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    q0.push_back('{1'b0, 5'd7, 32'd0});
    drive(0);
    repeat (2) @(negedge clk);
    n_tests++;
    if ({ram_cen, ram_wen, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, init_done} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctl got %b want 0000000", {ram_cen, ram_wen, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, init_done});
    end
    n_tests++;
    if (ram_addr !== 5'd0 || ram_din !== 32'd0) begin
      n_fail++; $display("FAIL reset_bus got addr=%h din=%h want 0", ram_addr, ram_din);
    end
    @(posedge clk); #1 reset_n = 1'b1;
`ifdef RAM_ARB_INIT_EN
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({ram_cen, ram_wen, init_done, m0_gnt} !== 4'b1100 || ram_addr !== 5'(k) || ram_din !== 32'd0) begin
        n_fail++; $display("FAIL init_write %0d got cen/wen/done/gnt=%b addr=%h din=%h want 1100 addr=%h din=0",
                           k, {ram_cen, ram_wen, init_done, m0_gnt}, ram_addr, ram_din, 5'(k));
      end
    end
`else
    @(negedge clk);
    n_tests++;
    if (init_done !== 1'b0 || m0_gnt !== 1'b0) begin
      n_fail++; $display("FAIL pre_init got done=%b gnt=%b want 0 0", init_done, m0_gnt);
    end
`endif
    @(posedge clk); #1;
    n_tests++;
    if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done got %b want 1", init_done); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); model_step();
      n_tests++;
      if ({m1_gnt, m0_gnt, ram_cen, ram_wen, m1_rvalid, m0_rvalid} !== {e_gnt, e_cen, e_wen, e_rv1, e_rv0}) begin
        n_fail++; $display("FAIL t1_ctl k=%0d got %b want %b", k, {m1_gnt, m0_gnt, ram_cen, ram_wen, m1_rvalid, m0_rvalid}, {e_gnt, e_cen, e_wen, e_rv1, e_rv0});
      end
      if (k == 0) begin
        n_tests++;
        if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL t1_gnt got %b want 1", m0_gnt); end
      end
      if (k == 2) begin
        n_tests++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'd0) begin
          n_fail++; $display("FAIL t1_read got rv=%b data=%h want 1 00000000", m0_rvalid, m0_rdata);
        end
      end
      @(posedge clk); #1 drive(0);
    end
  endtask

  task automatic test_single_master();
    e_gnt = '0;
    q0.push_back('{1'b1, 5'h01, 32'h1234_5678});
    q0.push_back('{1'b0, 5'h01, 32'h0});
    drive(0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); model_step();
      n_tests++;
      if ({m1_gnt, m0_gnt, ram_cen, ram_wen, m1_rvalid, m0_rvalid} !== {e_gnt, e_cen, e_wen, e_rv1, e_rv0}) begin
        n_fail++; $display("FAIL t2_ctl k=%0d got %b want %b", k, {m1_gnt, m0_gnt, ram_cen, ram_wen, m1_rvalid, m0_rvalid}, {e_gnt, e_cen, e_wen, e_rv1, e_rv0});
      end
      if (e_cen) begin
        n_tests++;
        if (ram_addr !== e_addr || (e_wen && ram_din !== e_din)) begin
          n_fail++; $display("FAIL t2_pins k=%0d got addr=%h din=%h want addr=%h din=%h", k, ram_addr, ram_din, e_addr, e_din);
        end
      end
      if (k < 2) begin
        n_tests++;
        if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL t2_gnt k=%0d got %b want 1", k, m0_gnt); end
      end
      if (k == 3) begin
        n_tests++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h1234_5678) begin
          n_fail++; $display("FAIL t2_read got rv=%b data=%h want 1 12345678", m0_rvalid, m0_rdata);
        end
      end
      @(posedge clk); #1 drive(0);
    end
  endtask

  task automatic test_contention();
    logic [1:0] prev_g;
    e_gnt = '0;
    q0.push_back('{1'b1, 5'd0, 32'hFFFF_FFFF});
    q1.push_back('{1'b1, 5'd1, 32'h0000_0001});
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b0, 5'd0, 32'h0});
      q1.push_back('{1'b0, 5'd1, 32'h0});
    end
    drive(0);
    prev_g = '0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk); model_step();
      n_tests++;
      if ({m1_gnt, m0_gnt, ram_cen, ram_wen, m1_rvalid, m0_rvalid} !== {e_gnt, e_cen, e_wen, e_rv1, e_rv0}) begin
        n_fail++; $display("FAIL t3_ctl k=%0d got %b want %b", k, {m1_gnt, m0_gnt, ram_cen, ram_wen, m1_rvalid, m0_rvalid}, {e_gnt, e_cen, e_wen, e_rv1, e_rv0});
      end
      n_tests++;
      if ({m1_rdata, m0_rdata} !== {e_rd1, e_rd0}) begin
        n_fail++; $display("FAIL t3_data k=%0d got %h %h want %h %h", k, m1_rdata, m0_rdata, e_rd1, e_rd0);
      end
      if (k > 0 && k < 10) begin
        n_tests++;
        if ({m1_gnt, m0_gnt} !== {prev_g[0], prev_g[1]}) begin
          n_fail++; $display("FAIL t3_alternate k=%0d got %b want %b", k, {m1_gnt, m0_gnt}, {prev_g[0], prev_g[1]});
        end
      end
      n_tests++;
      if ((m0_rvalid && m1_rvalid) || (m0_rvalid && m0_rdata !== 32'hFFFF_FFFF) || (m1_rvalid && m1_rdata !== 32'h1)) begin
        n_fail++; $display("FAIL t3_resp k=%0d got rv=%b%b d0=%h d1=%h want one rv, d0=ffffffff d1=00000001",
                           k, m1_rvalid, m0_rvalid, m0_rdata, m1_rdata);
      end
      prev_g = e_gnt;
      @(posedge clk); #1 drive(0);
    end
  endtask

  task automatic test_ordering();
    e_gnt = '0;
    q0.push_back('{1'b1, 5'd3, 32'hA5A5_A5A5});
    drive(0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); model_step();
      n_tests++;
      if ({m1_gnt, m0_gnt, ram_cen, ram_wen, m1_rvalid, m0_rvalid} !== {e_gnt, e_cen, e_wen, e_rv1, e_rv0}) begin
        n_fail++; $display("FAIL t4_ctl k=%0d got %b want %b", k, {m1_gnt, m0_gnt, ram_cen, ram_wen, m1_rvalid, m0_rvalid}, {e_gnt, e_cen, e_wen, e_rv1, e_rv0});
      end
      if (k == 3) begin
        n_tests++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hA5A5_A5A5) begin
          n_fail++; $display("FAIL t4_raw got rv=%b data=%h want 1 a5a5a5a5", m1_rvalid, m1_rdata);
        end
      end
      if (k == 0) q1.push_back('{1'b0, 5'd3, 32'h0});
      @(posedge clk); #1 drive(0);
    end
  endtask

  task automatic test_idle();
    e_gnt = '0;
    drive(0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); model_step();
      n_tests++;
      if ({ram_cen, ram_wen, m0_rvalid, m1_rvalid, m0_gnt, m1_gnt} !== 6'b0 || e_cen !== 1'b0) begin
        n_fail++; $display("FAIL t6_idle k=%0d got %b want 000000", k, {ram_cen, ram_wen, m0_rvalid, m1_rvalid, m0_gnt, m1_gnt});
      end
      @(posedge clk); #1 drive(0);
    end
  endtask

  task automatic test_random();
    e_gnt = '0;
    drive(1);
    for (int k = 0; k < 320; k++) begin
      @(negedge clk); model_step();
      n_tests++;
      if ({m1_gnt, m0_gnt, ram_cen, ram_wen, m1_rvalid, m0_rvalid} !== {e_gnt, e_cen, e_wen, e_rv1, e_rv0}) begin
        n_fail++; $display("FAIL rnd_ctl k=%0d got %b want %b", k, {m1_gnt, m0_gnt, ram_cen, ram_wen, m1_rvalid, m0_rvalid}, {e_gnt, e_cen, e_wen, e_rv1, e_rv0});
      end
      n_tests++;
      if ({m1_rdata, m0_rdata} !== {e_rd1, e_rd0}) begin
        n_fail++; $display("FAIL rnd_data k=%0d got %h %h want %h %h", k, m1_rdata, m0_rdata, e_rd1, e_rd0);
      end
      if (e_cen) begin
        n_tests++;
        if (ram_addr !== e_addr || (e_wen && ram_din !== e_din)) begin
          n_fail++; $display("FAIL rnd_pins k=%0d got addr=%h din=%h want addr=%h din=%h", k, ram_addr, ram_din, e_addr, e_din);
        end
      end
      @(posedge clk); #1 drive(k < 300);
    end
  endtask

  task automatic test_reset_midop();
    bit seen_rv;
    e_gnt = '0;
    q1.push_back('{1'b0, 5'd1, 32'h0});
    drive(0);
    @(negedge clk); model_step();
    n_tests++;
    if (m1_gnt !== 1'b1 || e_gnt !== 2'b10) begin
      n_fail++; $display("FAIL t5_gnt got %b want 1", m1_gnt);
    end
    @(posedge clk); #1 drive(0);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({ram_cen, ram_wen, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, init_done} !== 7'b0 || ram_addr !== 5'd0 || ram_din !== 32'd0) begin
      n_fail++; $display("FAIL t5_async got %b addr=%h din=%h want 0",
                         {ram_cen, ram_wen, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, init_done}, ram_addr, ram_din);
    end
    q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
`ifdef RAM_ARB_INIT_EN
    @(posedge clk); #1;
    n_tests++;
    if (ram_cen !== 1'b1 || ram_wen !== 1'b1 || ram_addr !== 5'd0) begin
      n_fail++; $display("FAIL t5_init_restart got cen=%b wen=%b addr=%h want 1 1 00", ram_cen, ram_wen, ram_addr);
    end
`endif
    seen_rv = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m0_rvalid || m1_rvalid) seen_rv = 1;
    end
    n_tests++;
    if (seen_rv || init_done !== 1'b1) begin
      n_fail++; $display("FAIL t5_after got rvalid_seen=%0d done=%b want 0 1", seen_rv, init_done);
    end
  endtask

  initial begin
    foreach (ram_mem[i]) ram_mem[i] = '0;
    foreach (mdl_mem[i]) mdl_mem[i] = '0;
    ram_dout = '0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    reset_n = 1'b0;
    test_reset();
    test_single_master();
    test_contention();
    test_ordering();
    test_idle();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule
